// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: envelope state codes, note width and
// the allocator FSM encoding.
package synth_pkg;

  localparam int NOTE_W = 7;

  typedef enum logic [2:0] {
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4,
    ENV_BLANK   = 3'd5
  } env_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters: one strobe clears the chosen voice and
// ages every other voice by one.
module voice_age_tracker #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bump,
  input  logic [IDX_W-1:0]            clr_idx,
  output logic [AGE_W*NUM_VOICES-1:0] ages
);

  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (bump) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (i == int'(clr_idx)) begin
          age_q[i] <= '0;
        end else if (age_q[i] != '1) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  assign ages = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: binds note-on/off requests to envelope voices,
// scanning one voice per cycle and stealing the oldest voice when none is free.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = synth_pkg::NOTE_W,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic                         note_on,
  input  logic [NOTE_W-1:0]            note_num,
  input  logic [NOTE_W-1:0]            note_vel,
  input  logic [5*NUM_VOICES-1:0]      voice_state,
  output logic [NUM_VOICES-1:0]        new_note_pulse,
  output logic [NUM_VOICES-1:0]        release_note_pulse,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]        voice_held,
  output logic                         steal_pulse,
  output logic [1:0]                   dbg_state
);
  import synth_pkg::*;

  localparam int IDX_W = $clog2(NUM_VOICES);

  // Handshake: a request transfers on a clock edge where note_valid && note_ready;
  // note_ready is high only in IDLE, so a valid held through SCAN/ISSUE is not queued.
  alloc_state_e state_q, state_d;

  logic [IDX_W-1:0]                  scan_idx;
  logic                              req_on;
  logic [NOTE_W-1:0]                 req_note, req_vel;
  logic                              match_found, free_found, rel_found;
  logic [IDX_W-1:0]                  match_idx, free_idx, rel_idx, old_idx;
  logic [AGE_W-1:0]                  rel_age, old_age;
  logic [NUM_VOICES-1:0]             held_q;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, vel_q;
  logic [NUM_VOICES-1:0][4:0]        vstate;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  ages;
  logic [AGE_W*NUM_VOICES-1:0]       ages_flat;
  logic                              accept, scan_last, issue, do_on, do_off, stealing;
  logic                              cur_held, cur_blank;
  logic [AGE_W-1:0]                  cur_age;
  logic [IDX_W-1:0]                  target;
  logic                              unused_state_bits;

  assign vstate    = voice_state;
  assign ages      = ages_flat;
  assign accept    = (state_q == IDLE) && note_valid;
  assign scan_last = (scan_idx == IDX_W'(NUM_VOICES - 1));
  assign cur_held  = held_q[scan_idx];
  assign cur_blank = (vstate[scan_idx][2:0] == ENV_BLANK);
  assign cur_age   = ages[scan_idx];

  always_comb begin
    unused_state_bits = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      unused_state_bits = unused_state_bits ^ (^vstate[i][4:3]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (scan_last) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Note-on target priority: retrigger match, free, oldest released, then steal.
  always_comb begin
    target   = old_idx;
    stealing = 1'b0;
    if (!req_on || match_found) target = match_idx;
    else if (free_found)        target = free_idx;
    else if (rel_found)         target = rel_idx;
    else                        stealing = 1'b1;
  end

  assign issue              = (state_q == ISSUE);
  assign do_on              = issue && req_on;
  assign do_off             = issue && !req_on && match_found;
  assign note_ready         = (state_q == IDLE);
  assign new_note_pulse     = do_on  ? (NUM_VOICES'(1) << target)    : '0;
  assign release_note_pulse = do_off ? (NUM_VOICES'(1) << match_idx) : '0;
  assign steal_pulse        = do_on && stealing;
  assign voice_note         = note_q;
  assign voice_vel          = vel_q;
  assign voice_held         = held_q;
  assign dbg_state          = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx    <= '0;
      req_on      <= 1'b0;
      req_note    <= '0;
      req_vel     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      rel_idx     <= '0;
      old_idx     <= '0;
      rel_age     <= '0;
      old_age     <= '0;
      held_q      <= '0;
      note_q      <= '0;
      vel_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_on      <= note_on && (note_vel != '0);
          req_note    <= note_num;
          req_vel     <= note_vel;
          scan_idx    <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          rel_found   <= 1'b0;
          match_idx   <= '0;
          free_idx    <= '0;
          rel_idx     <= '0;
          old_idx     <= '0;
          rel_age     <= '0;
          old_age     <= '0;
        end
        SCAN: begin
          if (cur_held && note_q[scan_idx] == req_note && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!cur_held && cur_blank && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (!cur_held && (!rel_found || cur_age > rel_age)) begin
            rel_found <= 1'b1;
            rel_idx   <= scan_idx;
            rel_age   <= cur_age;
          end
          if (cur_age > old_age) begin
            old_idx <= scan_idx;
            old_age <= cur_age;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        ISSUE: begin
          if (do_on) begin
            note_q[target] <= req_note;
            vel_q[target]  <= req_vel;
            held_q[target] <= 1'b1;
          end
          if (do_off) held_q[match_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .bump    (do_on),
    .clr_idx (target),
    .ages    (ages_flat)
  );

endmodule
